prog_mem_loadable: RTL
======================

Name: prog_mem_loadable

Overview:
- Parametrised, run-time-loadable successor to the fixed 256x8 program ROM.
- Sits between the MPU fetch path and an external load source (UART or test host).
- Serves instruction fetches with selectable read latency.
- Accepts a streamed program image over a valid/ready port, holding the CPU off (executing NOP_WORD) while loading.

Parameters:
- DATA_W, 8, instruction word width in bits.
- ADDR_W, 8, address width; DEPTH = 2**ADDR_W words.
- READ_LAT, 1, fetch latency in cycles; legal values 1 or 2; any other value is an elaboration error.
- NOP_WORD, 0, word presented on q while held and at reset; also the memory init value.

Ports:
- clock  in  1  single system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  ADDR_W  fetch address.
- rd_en  in  1  fetch request, sampled each edge.
- q  out  DATA_W  fetched word.
- q_valid  out  1  q holds the word for a request made READ_LAT cycles earlier.
- cpu_hold  out  1  CPU must stall; high while loading.
- ld_start  in  1  single-cycle pulse: begin (or restart) a load at address 0.
- ld_valid  in  1  load beat valid.
- ld_data  in  DATA_W  load beat data.
- ld_last  in  1  marks final beat; qualified by ld_valid.
- ld_ready  out  1  block accepts a load beat.
- ld_done  out  1  one-cycle pulse when a load completes.
- ld_count  out  ADDR_W+1  words written by the last completed load.
- ld_checksum  out  DATA_W  see Optional Feature.

Behaviour:
- Reset (asynchronous assert, synchronous release): state RUN; q=NOP_WORD; q_valid=0; cpu_hold=0; ld_ready=0; ld_done=0; ld_count=0; ld_checksum=0; write pointer=0. Memory array is not cleared by reset; at elaboration it initialises to NOP_WORD.
- FSM states: RUN, LOAD, FINISH.
- RUN:
  - ld_start=1 -> LOAD, pointer := 0, read pipeline flushed (q_valid=0).
  - Otherwise stay in RUN.
- LOAD:
  - ld_ready=1, cpu_hold=1.
  - Each ld_valid & ld_ready: mem[ptr] := ld_data, ptr++.
  - A beat with ld_last=1, or a beat written at ptr=DEPTH-1, -> FINISH. The latter is auto-terminate overflow; further beats are not accepted.
  - ld_start=1 -> restart: ptr := 0, stay in LOAD. Any beat presented in that same cycle is dropped. Words already written are kept.
- FINISH (one cycle):
  - ld_ready=0, cpu_hold=1, ld_done=1, ld_count := beats accepted (1..DEPTH).
  - -> RUN.
- cpu_hold = (state != RUN); combinational from the state register.
- Fetch (RUN only):
  - READ_LAT=1: at the edge sampling rd_en=1, q := mem[address] and q_valid := 1. Timing matches the legacy ROM.
  - READ_LAT=2: data passes through an extra output register; q and q_valid appear one cycle later.
  - rd_en=0: q holds its previous value and q_valid=0.
- Outside RUN, q is forced to NOP_WORD with q_valid=0 from the cycle after ld_start, and in-flight fetches are discarded.
- ld_start in the same cycle as rd_en in RUN: load wins; the fetch is discarded.
- ld_valid while in RUN or FINISH: ignored (ld_ready=0).
- Reset mid-load: returns to RUN, cpu_hold=0, ld_count=0. Partially written words remain.

Optional Feature:
- Macro: PMEM_CHECKSUM_EN.
- Defined:
  - ld_checksum accumulates the modulo-2^DATA_W sum of accepted beats.
  - It clears on ld_start and is valid from the ld_done cycle until the next ld_start.
  - A restart discards the partial sum.
- Undefined: ld_checksum tied to 0 and no accumulator logic is generated.

Test Plan:
- Reset release, READ_LAT=1, memory at init, rd_en=1 at address 0x10 -> q=0x00, q_valid=1 one cycle later; cpu_hold=0 throughout.
- ld_start, then beats 0xE1,0x4F,0xB6 (last on 0xB6) -> ld_ready high 3 cycles, ld_done pulse with ld_count=3, checksum 0xE6 if enabled; fetches of 0,1,2 return E1,4F,B6.
- READ_LAT=2, back-to-back fetches of addresses 0,1,2 -> q shows mem[0],mem[1],mem[2] starting 2 cycles after the first request, q_valid continuous.
- ld_start with rd_en=1 and a pending fetch -> q_valid drops, q=NOP_WORD next cycle, cpu_hold=1 until the cycle after ld_done.
- Stream DEPTH+2 beats with no ld_last (ADDR_W=4) -> 16 beats accepted, ld_ready low after the 16th, ld_count=16, remaining 2 beats not written.
- Restart at beat 2 (ld_start), then load 0xAA with ld_last; separately assert reset_n low mid-load -> restart yields ld_count=1 and mem[0]=0xAA; reset returns RUN, cpu_hold=0, ld_done never pulses.

Source files
------------

// File: rtl/prog_mem_loadable_if.sv
// Fetch and program-load port bundle for prog_mem_loadable.
// master = CPU fetch path plus load source; slave = the memory block.
interface prog_mem_loadable_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] address;
    logic              rd_en;
    logic [DATA_W-1:0] q;
    logic              q_valid;
    logic              cpu_hold;
    logic              ld_start;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;
    logic              ld_ready;
    logic              ld_done;
    logic [ADDR_W:0]   ld_count;
    logic [DATA_W-1:0] ld_checksum;

    modport master (
        output address, rd_en, ld_start, ld_valid, ld_data, ld_last,
        input  q, q_valid, cpu_hold, ld_ready, ld_done, ld_count, ld_checksum
    );

    modport slave (
        input  address, rd_en, ld_start, ld_valid, ld_data, ld_last,
        output q, q_valid, cpu_hold, ld_ready, ld_done, ld_count, ld_checksum
    );
endinterface

// File: rtl/prog_mem_loadable.sv
// Run-time loadable program memory: serves CPU fetches (READ_LAT 1 or 2) and accepts a
// streamed image over valid/ready while holding the CPU. Optional: PMEM_CHECKSUM_EN.
module prog_mem_loadable #(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 8,
    parameter int                READ_LAT = 1,
    parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
    input logic                clock,
    input logic                reset_n,
    prog_mem_loadable_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_read_lat
        $error("prog_mem_loadable: READ_LAT must be 1 or 2, got %0d", READ_LAT);
    end

    typedef enum logic [1:0] {
        ST_RUN,
        ST_LOAD,
        ST_FINISH
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W:0]   ld_count_q;
    logic              restart;
    logic              beat_fire;
    logic              load_end;
    logic              flush;
    logic [DATA_W-1:0] rd_q;
    logic              rd_v;

    logic [DATA_W-1:0] mem [DEPTH] = '{default: NOP_WORD};

    // A start pulse during FINISH is ignored; the load has already completed.
    assign restart   = bus.ld_start && (state_q != ST_FINISH);
    assign beat_fire = (state_q == ST_LOAD) && bus.ld_valid && !bus.ld_start;
    assign load_end  = beat_fire && (bus.ld_last || (&wr_ptr));
    assign flush     = (state_q != ST_RUN) || bus.ld_start;

    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) begin
            state_q    <= ST_RUN;
            wr_ptr     <= '0;
            ld_count_q <= '0;
        end else begin
            state_q <= state_d;
            if (restart) begin
                wr_ptr <= '0;
            end else if (beat_fire) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (load_end) begin
                ld_count_q <= (ADDR_W+1)'(wr_ptr) + (ADDR_W+1)'(1);
            end
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        state_d      = state_q;
        bus.cpu_hold = 1'b1;
        bus.ld_ready = 1'b0;
        bus.ld_done  = 1'b0;
        case (state_q)
            ST_RUN: begin
                bus.cpu_hold = 1'b0;
                if (bus.ld_start) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                bus.ld_ready = 1'b1;
                if (load_end) state_d = ST_FINISH;
            end
            ST_FINISH: begin
                bus.ld_done = 1'b1;
                state_d     = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    assign bus.ld_count = ld_count_q;

    // NOTE: the array is deliberately left out of reset; a reset mid-load keeps written words.
    always_ff @(posedge clock) begin
        if (beat_fire) mem[wr_ptr] <= bus.ld_data;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_q <= NOP_WORD;
            rd_v <= 1'b0;
        end else if (flush) begin
            rd_q <= NOP_WORD;
            rd_v <= 1'b0;
        end else if (bus.rd_en) begin
            rd_q <= mem[bus.address];
            rd_v <= 1'b1;
        end else begin
            rd_v <= 1'b0;
        end
    end

    if (READ_LAT == 2) begin : g_lat2
        logic [DATA_W-1:0] out_q;
        logic              out_v;

        // The second stage is flushed together with the first so no stale fetch escapes a load.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                out_q <= NOP_WORD;
                out_v <= 1'b0;
            end else if (flush) begin
                out_q <= NOP_WORD;
                out_v <= 1'b0;
            end else begin
                out_q <= rd_q;
                out_v <= rd_v;
            end
        end

        assign bus.q       = out_q;
        assign bus.q_valid = out_v;
    end else begin : g_lat1
        assign bus.q       = rd_q;
        assign bus.q_valid = rd_v;
    end

`ifdef PMEM_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            csum_q <= '0;
        end else if (restart) begin
            csum_q <= '0;
        end else if (beat_fire) begin
            csum_q <= csum_q + bus.ld_data;
        end
    end

    assign bus.ld_checksum = csum_q;
`else
    assign bus.ld_checksum = '0;
`endif

endmodule
